// File: rtl/commit_trace_fifo_if.sv
// Commit-side inputs and trace-record outputs of the commit trace FIFO.
// master drives commits and consumes records; slave is the FIFO itself.
interface commit_trace_fifo_if;
  logic [15:0] pc;
  logic        reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        halt;
  logic        rec_ready;
  logic        rec_valid;
  logic [2:0]  rec_kind;
  logic [15:0] rec_inum;
  logic [15:0] rec_pc;
  logic [15:0] rec_value;
  logic [15:0] rec_addr;
  logic [3:0]  rec_reg;
  logic [15:0] inst_count;
  logic [31:0] cycle_count;
  logic        overflow;
  logic        done;

  modport master (
    output pc, reg_write, write_reg, write_data,
    output mem_read, mem_write, mem_addr, mem_data,
    output halt, rec_ready,
    input  rec_valid, rec_kind, rec_inum, rec_pc,
    input  rec_value, rec_addr, rec_reg,
    input  inst_count, cycle_count, overflow, done
  );

  modport slave (
    input  pc, reg_write, write_reg, write_data,
    input  mem_read, mem_write, mem_addr, mem_data,
    input  halt, rec_ready,
    output rec_valid, rec_kind, rec_inum, rec_pc,
    output rec_value, rec_addr, rec_reg,
    output inst_count, cycle_count, overflow, done
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit trace recorder: one record per RUN cycle into a DEPTH-entry FIFO,
// then drains after HALT is captured and parks in DONE until reset.
module commit_trace_fifo #(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  commit_trace_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] K_NOP   = 3'd0;
  localparam logic [2:0] K_REG   = 3'd1;
  localparam logic [2:0] K_LOAD  = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [15:0] value;
    logic [15:0] addr;
    logic [3:0]  rd;
  } rec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  rec_t        mem [DEPTH];
  rec_t        new_rec;
  rec_t        head;
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic [15:0] inst_q;
  logic [31:0] cyc_q;
  logic        ovf_q;

  logic empty;
  logic full;
  logic pop;
  logic run;
  logic can_push;
  logic push;
  logic drop;
  logic is_halt;
  logic is_load;
  logic is_reg;
  logic is_hlt_in;
  logic is_store;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = ~empty & bus.rec_ready;
  assign run   = (state_q == RUN);

  // Kind terms made mutually exclusive so the decoder is a true one-hot.
  assign is_load   = bus.reg_write & bus.mem_read;
  assign is_reg    = bus.reg_write & ~bus.mem_read;
  assign is_hlt_in = ~bus.reg_write & bus.halt;
  assign is_store  = ~bus.reg_write & ~bus.halt & bus.mem_write;

  always_comb begin
    new_rec      = '0;
    new_rec.pc   = bus.pc;
    new_rec.inum = inst_q;
    new_rec.kind = K_NOP;
    unique case (1'b1)
      is_load: begin
        new_rec.kind  = K_LOAD;
        new_rec.rd    = bus.write_reg;
        new_rec.value = bus.write_data;
        new_rec.addr  = bus.mem_addr;
      end
      is_reg: begin
        new_rec.kind  = K_REG;
        new_rec.rd    = bus.write_reg;
        new_rec.value = bus.write_data;
      end
      is_hlt_in: new_rec.kind = K_HALT;
      is_store: begin
        new_rec.kind  = K_STORE;
        new_rec.value = bus.mem_data;
        new_rec.addr  = bus.mem_addr;
      end
      default: new_rec.kind = K_NOP;
    endcase
  end

  // A full FIFO still accepts when the head leaves the same edge.
  assign is_halt  = (new_rec.kind == K_HALT);
  assign can_push = ~full | pop;
  assign push     = run & can_push;
  assign drop     = run & ~can_push & ~is_halt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (push && is_halt) state_d = DRAIN;
      DRAIN:   if (empty) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    head            = empty ? '0 : mem[rd_q[AW-1:0]];
    bus.rec_valid   = ~empty;
    bus.rec_kind    = head.kind;
    bus.rec_inum    = head.inum;
    bus.rec_pc      = head.pc;
    bus.rec_value   = head.value;
    bus.rec_addr    = head.addr;
    bus.rec_reg     = head.rd;
    bus.done        = (state_q == DONE);
    bus.inst_count  = inst_q;
    bus.cycle_count = cyc_q;
    bus.overflow    = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      inst_q <= '0;
      cyc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)         wr_q   <= wr_q + (AW+1)'(1);
      if (pop)          rd_q   <= rd_q + (AW+1)'(1);
      if (push || drop) inst_q <= inst_q + 16'd1;
      if (run && (cyc_q != '1))
        cyc_q <= cyc_q + 32'd1;
      if (drop)         ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_q[AW-1:0]] <= new_rec;
  end

endmodule
